// File: rtl/pi_multi_pkg.sv
// Shared definitions for the priority-interrupt controller: command opcodes,
// FSM state type, level-width and CONI status field helpers.
package pi_multi_pkg;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_EN_SET = 3'd1;
  localparam logic [2:0] OP_EN_CLR = 3'd2;
  localparam logic [2:0] OP_SW_SET = 3'd3;
  localparam logic [2:0] OP_SW_CLR = 3'd4;
  localparam logic [2:0] OP_ON     = 3'd5;
  localparam logic [2:0] OP_OFF    = 3'd6;
  localparam logic [2:0] OP_CLEAR  = 3'd7;

  typedef enum logic {ST_IDLE = 1'b0, ST_PRESENT = 1'b1} pi_state_t;

  function automatic int pi_lw(input int levels);
    return $clog2(levels + 1);
  endfunction

  // piSTATUS = {piON, levelEN, inProg}
  function automatic int pi_stat_ip_lsb(input int levels);
    return 0 * levels;
  endfunction

  function automatic int pi_stat_en_lsb(input int levels);
    return levels;
  endfunction

  function automatic int pi_stat_on_bit(input int levels);
    return 2 * levels;
  endfunction

endpackage

// File: rtl/pi_multi_prienc.sv
// Lowest-index priority encoder: returns (index of lowest set bit)+1, or 0
// when the vector is empty, matching the "level n, 0 = none" numbering.
module pi_prienc #(
  parameter int N = 7,
  parameter int W = 3
) (
  input  logic [N-1:0] i_vec,
  output logic [W-1:0] o_idx
);

  always_comb begin
    o_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = W'(i + 1);
    end
  end

endmodule

// File: rtl/pi_multi.sv
// Parametrised priority-interrupt controller: merges hardware and program
// requests, tracks levels in progress and presents one level at a time.
module pi_multi
  import pi_multi_pkg::*;
#(
  parameter  int LEVELS  = 7,
  parameter  int SOURCES = 2,
  localparam int LW      = pi_lw(LEVELS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clken,
  input  logic [SOURCES*LEVELS-1:0]   reqIN,
  input  logic [2:0]                  cmdOP,
  input  logic                        cmdWR,
  input  logic [LEVELS-1:0]           cmdMASK,
  input  logic                        piACK,
  input  logic                        piDISMISS,
  output logic                        piINTR,
  output logic [LW-1:0]               piREQPRI,
  output logic [LW-1:0]               piCURPRI,
  output logic [2*LEVELS:0]           piSTATUS
);

  // Handshake: piINTR/piREQPRI form a valid; piACK is the ready and only
  // counts in a cycle where piINTR=1, applying to the piREQPRI shown then.

  localparam int ST_IP = pi_stat_ip_lsb(LEVELS);
  localparam int ST_EN = pi_stat_en_lsb(LEVELS);
  localparam int ST_ON = pi_stat_on_bit(LEVELS);

  pi_state_t         r_state;
  logic              r_on;
  logic [LEVELS-1:0] r_en;
  logic [LEVELS-1:0] r_sw;
  logic [LEVELS-1:0] r_ip;
  logic              r_intr;
  logic [LW-1:0]     r_reqpri;
  logic [LW-1:0]     r_curpri;

  logic              w_ack;
  logic              w_clear;
  logic [LEVELS-1:0] w_hw;
  logic [LEVELS-1:0] w_ack_bit;
  logic [LEVELS-1:0] w_dis_bit;
  logic              w_on_n;
  logic [LEVELS-1:0] w_en_n;
  logic [LEVELS-1:0] w_sw_n;
  logic [LEVELS-1:0] w_ip_n;
  logic [LEVELS-1:0] w_above;
  logic [LEVELS-1:0] w_elig;
  logic [LW-1:0]     w_cur_n;
  logic [LW-1:0]     w_req_n;

  assign w_ack   = piACK & r_intr;
  assign w_clear = cmdWR & (cmdOP == OP_CLEAR);

  always_comb begin
    w_hw = '0;
    for (int s = 0; s < SOURCES; s++) w_hw = w_hw | reqIN[s*LEVELS +: LEVELS];
  end

  always_comb begin
    w_ack_bit = '0;
    w_dis_bit = '0;
    for (int n = 1; n <= LEVELS; n++) begin
      if (w_ack && r_reqpri == LW'(n))     w_ack_bit[n-1] = 1'b1;
      if (piDISMISS && r_curpri == LW'(n)) w_dis_bit[n-1] = 1'b1;
    end
  end

  // The ack drops a program request only when no enabled hardware request
  // backs that level; a same-cycle command is applied on top of that.
  always_comb begin
    w_on_n = r_on;
    w_en_n = r_en;
    w_sw_n = r_sw & ~(w_ack_bit & ~(w_hw & r_en));
    if (cmdWR) begin
      case (cmdOP)
        OP_EN_SET: w_en_n = w_en_n | cmdMASK;
        OP_EN_CLR: w_en_n = w_en_n & ~cmdMASK;
        OP_SW_SET: w_sw_n = w_sw_n | cmdMASK;
        OP_SW_CLR: w_sw_n = w_sw_n & ~cmdMASK;
        OP_ON:     w_on_n = 1'b1;
        OP_OFF:    w_on_n = 1'b0;
        default:   ;
      endcase
    end
    w_ip_n = (r_ip & ~w_dis_bit) | w_ack_bit;
  end

  pi_prienc #(.N(LEVELS), .W(LW)) u_cur (.i_vec(w_ip_n), .o_idx(w_cur_n));

  always_comb begin
    w_above = '0;
    for (int n = 1; n <= LEVELS; n++)
      w_above[n-1] = (w_cur_n == '0) || (LW'(n) < w_cur_n);
  end

  assign w_elig = {LEVELS{w_on_n}} & ((w_hw & w_en_n) | w_sw_n) & w_above;

  pi_prienc #(.N(LEVELS), .W(LW)) u_elig (.i_vec(w_elig), .o_idx(w_req_n));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_on     <= 1'b0;
      r_en     <= '0;
      r_sw     <= '0;
      r_ip     <= '0;
      r_intr   <= 1'b0;
      r_reqpri <= '0;
      r_curpri <= '0;
    end else if (clken) begin
      if (w_clear) begin
        r_state  <= ST_IDLE;
        r_on     <= 1'b0;
        r_en     <= '0;
        r_sw     <= '0;
        r_ip     <= '0;
        r_intr   <= 1'b0;
        r_reqpri <= '0;
        r_curpri <= '0;
      end else begin
        r_on     <= w_on_n;
        r_en     <= w_en_n;
        r_sw     <= w_sw_n;
        r_ip     <= w_ip_n;
        r_curpri <= w_cur_n;
        case (r_state)
          ST_IDLE: begin
            if (w_req_n != '0) begin
              r_state  <= ST_PRESENT;
              r_intr   <= 1'b1;
              r_reqpri <= w_req_n;
            end
          end
          ST_PRESENT: begin
            if (w_ack || w_req_n == '0) begin
              r_state  <= ST_IDLE;
              r_intr   <= 1'b0;
              r_reqpri <= '0;
            end else begin
              r_reqpri <= w_req_n;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign piINTR   = r_intr;
  assign piREQPRI = r_reqpri;
  assign piCURPRI = r_curpri;
  assign piSTATUS[ST_ON]            = r_on;
  assign piSTATUS[ST_EN +: LEVELS]  = r_en;
  assign piSTATUS[ST_IP +: LEVELS]  = r_ip;

endmodule

// File: tb/tb_pi_multi.sv
// Self-checking bench for pi_multi: directed scenarios plus randomized
// traffic against a set-based reference model, and a 15-level instance.
module tb_pi_multi;

  localparam int L   = 7;
  localparam int S   = 2;
  localparam int LW  = 3;
  localparam int L2  = 15;
  localparam int S2  = 4;
  localparam int LW2 = 4;
  localparam int OW  = 1 + LW + LW + 2*L + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic             clken = 1'b1;
  logic [S*L-1:0]   req   = '0;
  logic [2:0]       op    = '0;
  logic             wr    = 1'b0;
  logic [L-1:0]     mask  = '0;
  logic             ack   = 1'b0;
  logic             dis   = 1'b0;
  logic             intr;
  logic [LW-1:0]    reqpri;
  logic [LW-1:0]    curpri;
  logic [2*L:0]     status;

  logic             clken2 = 1'b1;
  logic [S2*L2-1:0] req2   = '0;
  logic [2:0]       op2    = '0;
  logic             wr2    = 1'b0;
  logic [L2-1:0]    mask2  = '0;
  logic             ack2   = 1'b0;
  logic             dis2   = 1'b0;
  logic             intr2;
  logic [LW2-1:0]   reqpri2;
  logic [LW2-1:0]   curpri2;
  logic [2*L2:0]    status2;

  int n_cmp = 0;
  int n_bad = 0;

  pi_multi #(.LEVELS(L), .SOURCES(S)) dut (
    .clk(clk), .rst(rst), .clken(clken), .reqIN(req), .cmdOP(op), .cmdWR(wr),
    .cmdMASK(mask), .piACK(ack), .piDISMISS(dis), .piINTR(intr),
    .piREQPRI(reqpri), .piCURPRI(curpri), .piSTATUS(status)
  );

  pi_multi #(.LEVELS(L2), .SOURCES(S2)) dut2 (
    .clk(clk), .rst(rst), .clken(clken2), .reqIN(req2), .cmdOP(op2), .cmdWR(wr2),
    .cmdMASK(mask2), .piACK(ack2), .piDISMISS(dis2), .piINTR(intr2),
    .piREQPRI(reqpri2), .piCURPRI(curpri2), .piSTATUS(status2)
  );

  always #5 clk = ~clk;

  // Reference model: sets of levels indexed by level number.
  bit m_on;
  bit m_en [1:L];
  bit m_sw [1:L];
  bit m_ip [1:L];
  bit m_intr;
  int m_req;

  task automatic model_reset();
    m_on = 0; m_intr = 0; m_req = 0;
    for (int n = 1; n <= L; n++) begin
      m_en[n] = 0; m_sw[n] = 0; m_ip[n] = 0;
    end
  endtask

  function automatic int model_cur();
    for (int n = 1; n <= L; n++) if (m_ip[n]) return n;
    return 0;
  endfunction

  task automatic model_step();
    bit hw [1:L];
    int cur;
    bit ack_ok;
    int lvl;
    if (!clken) return;
    for (int n = 1; n <= L; n++) begin
      hw[n] = 0;
      for (int s = 0; s < S; s++) if (req[s*L + n - 1]) hw[n] = 1;
    end
    ack_ok = ack && m_intr;
    lvl = m_req;
    cur = model_cur();
    if (wr && op == 3'd7) begin
      model_reset();
      return;
    end
    if (dis && cur != 0) m_ip[cur] = 0;
    if (ack_ok) begin
      m_ip[lvl] = 1;
      if (!(hw[lvl] && m_en[lvl])) m_sw[lvl] = 0;
    end
    if (wr) begin
      for (int n = 1; n <= L; n++) begin
        if (mask[n-1]) begin
          if (op == 3'd1) m_en[n] = 1;
          if (op == 3'd2) m_en[n] = 0;
          if (op == 3'd3) m_sw[n] = 1;
          if (op == 3'd4) m_sw[n] = 0;
        end
      end
      if (op == 3'd5) m_on = 1;
      if (op == 3'd6) m_on = 0;
    end
    if (ack_ok) begin
      m_intr = 0;
      m_req = 0;
      return;
    end
    cur = model_cur();
    m_req = 0;
    for (int n = L; n >= 1; n--)
      if (m_on && ((hw[n] && m_en[n]) || m_sw[n]) && (cur == 0 || n < cur)) m_req = n;
    m_intr = (m_req != 0);
  endtask

  function automatic logic [OW-1:0] model_outs();
    logic [L-1:0] en_v, ip_v;
    for (int n = 1; n <= L; n++) begin
      en_v[n-1] = m_en[n];
      ip_v[n-1] = m_ip[n];
    end
    return {m_intr, LW'(m_req), LW'(model_cur()), m_on, en_v, ip_v};
  endfunction

  task automatic idle_in();
    wr = 0; ack = 0; dis = 0; op = 3'd0; mask = '0;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    idle_in();
  endtask

  task automatic cmd(input logic [2:0] o, input logic [L-1:0] m);
    op = o; mask = m; wr = 1;
    cycle();
  endtask

  task automatic test_reset();
    rst = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({intr, reqpri, curpri, status} !== '0) begin
      n_bad++;
      $display("FAIL reset: got %h want 0", {intr, reqpri, curpri, status});
    end
    n_cmp++;
    if ({intr2, reqpri2, curpri2, status2} !== '0) begin
      n_bad++;
      $display("FAIL reset2: got %h want 0", {intr2, reqpri2, curpri2, status2});
    end
    rst = 1;
    cycle();
  endtask

  task automatic test_basic();
    cmd(3'd5, '0);
    cmd(3'd1, 7'h7F);
    req = '0; req[1*L + 2] = 1'b1;
    cycle();
    n_cmp++;
    if (intr !== 1'b1 || reqpri !== 3'd3) begin
      n_bad++;
      $display("FAIL basic_present: intr=%b req=%0d want 1/3", intr, reqpri);
    end
    ack = 1;
    cycle();
    n_cmp++;
    if (curpri !== 3'd3 || intr !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_ack: cur=%0d intr=%b want 3/0", curpri, intr);
    end
    cycle();
    n_cmp++;
    if ({intr, reqpri, curpri, status} !== model_outs()) begin
      n_bad++;
      $display("FAIL basic_hold: got %h want %h", {intr, reqpri, curpri, status}, model_outs());
    end
  endtask

  task automatic test_nested();
    req[4] = 1'b1;
    cycle();
    n_cmp++;
    if (intr !== 1'b0) begin
      n_bad++;
      $display("FAIL nested_lower: intr=%b want 0", intr);
    end
    req[1] = 1'b1;
    cycle();
    n_cmp++;
    if (intr !== 1'b1 || reqpri !== 3'd2) begin
      n_bad++;
      $display("FAIL nested_higher: intr=%b req=%0d want 1/2", intr, reqpri);
    end
    ack = 1;
    cycle();
    n_cmp++;
    if (curpri !== 3'd2) begin
      n_bad++;
      $display("FAIL nested_ack: cur=%0d want 2", curpri);
    end
    req = '0;
    dis = 1;
    cycle();
    n_cmp++;
    if (curpri !== 3'd3) begin
      n_bad++;
      $display("FAIL nested_dismiss: cur=%0d want 3", curpri);
    end
    dis = 1;
    cycle();
    n_cmp++;
    if (curpri !== 3'd0 || intr !== 1'b0) begin
      n_bad++;
      $display("FAIL nested_empty: cur=%0d intr=%b want 0/0", curpri, intr);
    end
  endtask

  task automatic test_disabled();
    cmd(3'd2, 7'b0001000);
    req = '0; req[3] = 1'b1;
    cycle();
    n_cmp++;
    if (intr !== 1'b0) begin
      n_bad++;
      $display("FAIL dis_hw: intr=%b want 0", intr);
    end
    cmd(3'd3, 7'b0001000);
    n_cmp++;
    if (intr !== 1'b1 || reqpri !== 3'd4) begin
      n_bad++;
      $display("FAIL dis_sw: intr=%b req=%0d want 1/4", intr, reqpri);
    end
    ack = 1;
    cycle();
    dis = 1;
    cycle();
    cycle();
    n_cmp++;
    if (intr !== 1'b0 || curpri !== 3'd0) begin
      n_bad++;
      $display("FAIL dis_swclr: intr=%b cur=%0d want 0/0", intr, curpri);
    end
    req = '0;
    cmd(3'd1, 7'b0001000);
  endtask

  task automatic test_preempt();
    req = '0; req[5] = 1'b1;
    cycle();
    n_cmp++;
    if (intr !== 1'b1 || reqpri !== 3'd6) begin
      n_bad++;
      $display("FAIL pre_6: intr=%b req=%0d want 1/6", intr, reqpri);
    end
    req[L + 0] = 1'b1;
    cycle();
    n_cmp++;
    if (intr !== 1'b1 || reqpri !== 3'd1) begin
      n_bad++;
      $display("FAIL pre_1: intr=%b req=%0d want 1/1", intr, reqpri);
    end
    ack = 1;
    cycle();
    n_cmp++;
    if (status[L-1:0] !== 7'b0000001 || curpri !== 3'd1) begin
      n_bad++;
      $display("FAIL pre_ack: ip=%b cur=%0d want 0000001/1", status[L-1:0], curpri);
    end
    req = '0;
    dis = 1;
    cycle();
  endtask

  task automatic test_clear();
    req = '0; req[1] = 1'b1;
    cycle();
    ack = 1; wr = 1; op = 3'd7; mask = '0;
    cycle();
    n_cmp++;
    if ({intr, reqpri, curpri, status} !== '0) begin
      n_bad++;
      $display("FAIL clear_ack: got %h want 0", {intr, reqpri, curpri, status});
    end
    cmd(3'd5, '0);
    cmd(3'd1, 7'h7F);
    req = '0; req[2] = 1'b1;
    cycle();
    #2;
    rst = 0;
    model_reset();
    #1;
    n_cmp++;
    if ({intr, reqpri, curpri, status} !== '0) begin
      n_bad++;
      $display("FAIL async_rst: got %h want 0", {intr, reqpri, curpri, status});
    end
    req = '0;
    @(negedge clk);
    rst = 1;
    cycle();
    cmd(3'd5, '0);
    cmd(3'd1, 7'h7F);
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 400; i++) begin
      req   = (S*L)'($urandom() & $urandom() & $urandom());
      clken = ($urandom_range(0, 9) != 0);
      ack   = ($urandom_range(0, 2) == 0);
      dis   = ($urandom_range(0, 4) == 0);
      r     = $urandom_range(0, 15);
      wr    = (r < 5);
      op    = (r == 0 && $urandom_range(0, 3) == 0) ? 3'd7 : 3'($urandom_range(1, 6));
      mask  = L'($urandom());
      cycle();
      n_cmp++;
      if ({intr, reqpri, curpri, status} !== model_outs()) begin
        n_bad++;
        $display("FAIL random[%0d]: got %h want %h", i, {intr, reqpri, curpri, status}, model_outs());
      end
    end
    clken = 1;
    req = '0;
  endtask

  task automatic test_sweep();
    logic [LW2:0]  held_o;
    logic [2*L2:0] held_s;
    op2 = 3'd5; wr2 = 1;
    @(posedge clk); #1;
    op2 = 3'd1; mask2 = 15'h7FFF;
    @(posedge clk); #1;
    wr2 = 0;
    req2 = '0; req2[3*L2 + 14] = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (intr2 !== 1'b1 || reqpri2 !== 4'hF) begin
      n_bad++;
      $display("FAIL sweep_l15: intr=%b req=%0d want 1/15", intr2, reqpri2);
    end
    held_o = {intr2, reqpri2};
    held_s = status2;
    clken2 = 0;
    for (int i = 0; i < 10; i++) begin
      req2 = (S2*L2)'({$urandom(), $urandom()});
      op2 = 3'($urandom_range(0, 7)); wr2 = 1; mask2 = L2'($urandom());
      ack2 = 1; dis2 = 1;
      @(posedge clk); #1;
      n_cmp++;
      if ({intr2, reqpri2} !== held_o || status2 !== held_s || curpri2 !== 4'd0) begin
        n_bad++;
        $display("FAIL sweep_hold[%0d]: got %h/%h want %h/%h", i, {intr2, reqpri2}, status2, held_o, held_s);
      end
    end
    wr2 = 0; ack2 = 0; dis2 = 0;
    req2 = '0;
    clken2 = 1;
    @(posedge clk); #1;
    n_cmp++;
    if (intr2 !== 1'b0 || reqpri2 !== 4'd0) begin
      n_bad++;
      $display("FAIL sweep_release: intr=%b req=%0d want 0/0", intr2, reqpri2);
    end
  endtask

  initial begin
    model_reset();
    idle_in();
    #2;
    test_reset();
    test_basic();
    test_nested();
    test_disabled();
    test_preempt();
    test_clear();
    test_random();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pi_multi.md
# pi_multi

Parametrised priority-interrupt controller for the KS10 CPU: the generalised successor to the fixed 7-level PI unit. It merges SOURCES hardware request vectors plus a program-requested vector and applies per-level enables. It tracks levels in progress and presents the highest eligible level to the microsequencer through a request/acknowledge handshake. It sits between the APR/UBA interrupt sources and the microcode interrupt dispatch, and drives piREQPRI/piCURPRI onto the DBUS and bus paths.

## Interface
- LEVELS, 7: number of priority levels; level 1 is highest priority, encoding 0 means "none"; legal range 1..15.
- SOURCES, 2: number of hardware request vectors (e.g. APR, UBA).
- LW, $clog2(LEVELS+1): level-number width (derived, not overridden).
- clk  in  1  CPU clock.
- rst  in  1  asynchronous, active-low reset.
- clken  in  1  datapath clock enable; all state advances only when high.
- reqIN  in  SOURCES*LEVELS  hardware requests, level-sensitive; source s level n at bit s*LEVELS+(n-1).
- cmdOP  in  3  command opcode, sampled when cmdWR=1.
- cmdWR  in  1  command strobe.
- cmdMASK  in  LEVELS  level mask for cmdOP; bit n-1 selects level n.
- piACK  in  1  microcode accepts the presented interrupt.
- piDISMISS  in  1  microcode dismisses the highest in-progress level.
- piINTR  out  1  interrupt presented; reset 0.
- piREQPRI  out  LW  level being presented, 0 if none; reset 0.
- piCURPRI  out  LW  highest level in progress, 0 if none; reset 0.
- piSTATUS  out  2*LEVELS+1  {piON, levelEN, inProg} for CONI readback; reset all 0.

## Operation
- State registers: piON, levelEN[1:L], swREQ[1:L], inProg[1:L], registered outputs.
- cmdOP, when cmdWR=1:
  - 0: nop.
  - 1: levelEN |= mask.
  - 2: levelEN &= ~mask.
  - 3: swREQ |= mask.
  - 4: swREQ &= ~mask.
  - 5: piON=1.
  - 6: piON=0.
  - 7: clear all state, same as reset.
- Pending[n] = piON & ((OR over sources of reqIN[n] & levelEN[n]) | swREQ[n]). Program requests bypass levelEN but still require piON.
- Eligible level = lowest-numbered pending n with n < piCURPRI, or any n if piCURPRI=0.
- FSM IDLE/PRESENT:
  - IDLE -> PRESENT when an eligible level exists; piREQPRI=level, piINTR=1.
  - PRESENT -> IDLE on piACK: set inProg[piREQPRI]; clear swREQ[piREQPRI] if it was the only source for that level.
  - PRESENT -> IDLE if the eligible level vanishes; piINTR drops.
  - In PRESENT, piREQPRI follows a higher eligible level if one appears; piACK always applies to the value shown in that cycle.
- piDISMISS clears inProg at piCURPRI. No-op when piCURPRI=0.
- piCURPRI = lowest-numbered set bit of inProg.

## Timing
- All outputs registered. A request/command effective in cycle N is reflected on outputs at N+1 when clken=1.
- piACK is ignored when piINTR=0.
- piACK and piDISMISS in the same cycle: dismiss applies to the old piCURPRI, then the ack sets the new bit.
- cmdWR with piACK in the same cycle: both apply.
- cmdOP 7 overrides any simultaneous piACK/piDISMISS.
- clken=0: state and outputs hold, and piACK, piDISMISS and cmdWR are ignored.
- Reset asserted mid-handshake: all state clears immediately (asynchronous); piINTR=0 with no pending ack.
- piON=0: no new presentation. inProg is kept so dismiss still works.

## Structure
- Shared package/header (pi.vh): cmdOP constants, piSTATUS field offsets, and the LW function.
- One sub-module, pi_prienc: parametrised lowest-index priority encoder, LEVELS-wide to LW-bit output, 0 if empty. Instanced twice, once for pending-above-current and once for piCURPRI.

## Test plan
- Reset, then cmdOP5 and cmdOP1 mask=7'h7F. Assert reqIN source 1 level 3 -> next cycle piINTR=1, piREQPRI=3. Assert piACK -> piCURPRI=3, piINTR=0 while the request stays asserted.
- With level 3 in progress, request level 5 -> no piINTR. Request level 2 -> piINTR=1, piREQPRI=2. piACK, then piDISMISS -> piCURPRI returns to 3.
- Level 4 disabled (cmdOP2 mask bit 3) with a hardware request -> no piINTR. cmdOP3 on level 4 -> piREQPRI=4. After ack, swREQ[4] clears.
- piINTR high at level 6, then level 1 request arrives -> piREQPRI switches to 1 next cycle. Ack in that cycle sets inProg[1] only.
- cmdOP7 in the same cycle as piACK -> all state 0 and inProg empty. Also assert rst low mid-PRESENT -> outputs 0 immediately.
- Parameter sweep LEVELS=15, SOURCES=4: request on source 3 level 15 is presented as piREQPRI=4'hF. clken held low for 10 cycles freezes the state.
